// File: rtl/cp0_int_ctrl_if.sv
//------------------------------------------------------------------------------
// cp0_int_ctrl_if : CP0 interrupt/exception controller bus between core and CP0
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface cp0_int_ctrl_if #(
  parameter int NUM_IRQ = 6
);
  logic [NUM_IRQ-1:0] irq;
  logic               exc_valid;
  logic [4:0]         exc_code;
  logic [31:0]        pc_in;
  logic               cp0_we;
  logic [4:0]         cp0_addr;
  logic [31:0]        cp0_wdata;
  logic               eret;
  logic [31:0]        cp0_rdata;
  logic               trap;
  logic [31:0]        trap_pc;
  logic               eret_redirect;
  logic [31:0]        epc_out;
  logic [2:0]         irq_id;
  logic               double_fault;

  modport master (
    output irq, exc_valid, exc_code, pc_in, cp0_we, cp0_addr, cp0_wdata, eret,
    input  cp0_rdata, trap, trap_pc, eret_redirect, epc_out, irq_id, double_fault
  );

  modport slave (
    input  irq, exc_valid, exc_code, pc_in, cp0_we, cp0_addr, cp0_wdata, eret,
    output cp0_rdata, trap, trap_pc, eret_redirect, epc_out, irq_id, double_fault
  );
endinterface

`default_nettype wire

// File: rtl/cp0_int_ctrl.sv
//------------------------------------------------------------------------------
// cp0_int_ctrl : Status/Cause/EPC registers, maskable interrupts, exceptions, eret
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cp0_int_ctrl #(
  parameter int          NUM_IRQ = 6,
  parameter logic [31:0] VECTOR  = 32'h8000_0180
) (
  input  logic          clk,
  input  logic          rst_n,
  cp0_int_ctrl_if.slave bus
);

  localparam logic [4:0] c_addr_status = 5'd12;
  localparam logic [4:0] c_addr_cause  = 5'd13;
  localparam logic [4:0] c_addr_epc    = 5'd14;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_ie;
  logic [NUM_IRQ-1:0] r_im;
  logic [NUM_IRQ-1:0] r_ip;
  logic [4:0]         r_exccode;
  logic [31:0]        r_epc;
  logic               r_double_fault;

  logic               w_exl;
  logic [NUM_IRQ-1:0] w_pending;
  logic               w_exc_take;
  logic               w_int_take;
  logic               w_take;
  logic               w_status_we;
  logic [2:0]         w_irq_id;
  logic [31:0]        w_status;
  logic [31:0]        w_cause;
  logic [31:0]        w_rdata;

  assign w_exl       = (r_state == HANDLER);
  assign w_pending   = r_ip & r_im;
  assign w_status_we = bus.cp0_we && (bus.cp0_addr == c_addr_status);
  // Exceptions ignore IE and pre-empt any pending interrupt.
  assign w_exc_take  = !w_exl && bus.exc_valid;
  assign w_int_take  = !w_exl && r_ie && !bus.exc_valid && (|w_pending);
  assign w_take      = w_exc_take || w_int_take;

  always_comb begin
    w_irq_id = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_pending[i]) w_irq_id = 3'(i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_take) begin
      w_state_nxt = HANDLER;
    end else if (bus.eret && w_exl) begin
      w_state_nxt = RUN;
    end else if (w_status_we) begin
      w_state_nxt = bus.cp0_wdata[1] ? HANDLER : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // IE/IM always follow an mtc0 even when a take lands in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ie           <= 1'b0;
      r_im           <= '0;
      r_ip           <= '0;
      r_exccode      <= 5'd0;
      r_epc          <= 32'd0;
      r_double_fault <= 1'b0;
    end else begin
      r_ip           <= bus.irq;
      r_double_fault <= w_exl && bus.exc_valid;
      if (w_status_we) begin
        r_ie <= bus.cp0_wdata[0];
        r_im <= bus.cp0_wdata[8 +: NUM_IRQ];
      end
      if (w_take) begin
        r_epc     <= bus.pc_in;
        r_exccode <= w_exc_take ? bus.exc_code : 5'd0;
      end else if (bus.cp0_we && (bus.cp0_addr == c_addr_epc)) begin
        r_epc <= bus.cp0_wdata;
      end
    end
  end

  always_comb begin
    w_status                = 32'd0;
    w_status[0]             = r_ie;
    w_status[1]             = w_exl;
    w_status[8 +: NUM_IRQ]  = r_im;
    w_cause                 = 32'd0;
    w_cause[6:2]            = r_exccode;
    w_cause[8 +: NUM_IRQ]   = r_ip;
    case (bus.cp0_addr)
      c_addr_status: w_rdata = w_status;
      c_addr_cause:  w_rdata = w_cause;
      c_addr_epc:    w_rdata = r_epc;
      default:       w_rdata = 32'd0;
    endcase
  end

  assign bus.cp0_rdata     = w_rdata;
  assign bus.trap          = w_take;
  assign bus.trap_pc       = VECTOR;
  assign bus.eret_redirect = bus.eret && w_exl;
  assign bus.epc_out       = r_epc;
  assign bus.irq_id        = w_irq_id;
  assign bus.double_fault  = r_double_fault;

endmodule

`default_nettype wire

// File: tb/tb_cp0_int_ctrl.sv
//------------------------------------------------------------------------------
// tb_cp0_int_ctrl : directed stimulus, per-cycle model comparison plus literal checks
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cp0_int_ctrl;
  localparam int          NUM_IRQ = 6;
  localparam logic [31:0] VECTOR  = 32'h8000_0180;
  localparam logic [31:0] c_wmask = 32'h0000_3F03;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  cp0_int_ctrl_if #(.NUM_IRQ(NUM_IRQ)) bus ();

  cp0_int_ctrl #(.NUM_IRQ(NUM_IRQ), .VECTOR(VECTOR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Architectural model: registers held as whole words, updated once per edge
  logic [31:0]        m_status;
  logic [NUM_IRQ-1:0] m_ip;
  logic [4:0]         m_code;
  logic [31:0]        m_epc;
  logic               m_df;
  bit                 m_ok = 0;

  function automatic logic [NUM_IRQ-1:0] m_pending();
    return m_ip & m_status[8 +: NUM_IRQ];
  endfunction

  function automatic logic m_int_trap();
    return !m_status[1] && !bus.exc_valid && m_status[0] && (m_pending() != 0);
  endfunction

  function automatic logic m_trap();
    return (!m_status[1] && bus.exc_valid) || m_int_trap();
  endfunction

  function automatic logic [2:0] m_lowest();
    logic [NUM_IRQ-1:0] p = m_pending();
    for (int i = 0; i < NUM_IRQ; i++) if (p[i]) return 3'(i);
    return 3'd0;
  endfunction

  function automatic logic [31:0] m_read();
    case (bus.cp0_addr)
      5'd12:   return m_status;
      5'd13:   return (32'(m_ip) << 8) | (32'(m_code) << 2);
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic take;
    logic old_exl;
    if (!rst_n) begin
      m_status = 32'd0; m_ip = '0; m_code = 5'd0; m_epc = 32'd0; m_df = 1'b0;
      m_ok = 1;
    end else if (m_ok) begin
      take    = m_trap();
      old_exl = m_status[1];
      m_df    = old_exl && bus.exc_valid;
      if (bus.cp0_we && bus.cp0_addr == 5'd12)
        m_status = (m_status & ~c_wmask) | (bus.cp0_wdata & c_wmask);
      if (take) begin
        m_status[1] = 1'b1;
        m_epc       = bus.pc_in;
        m_code      = bus.exc_valid ? bus.exc_code : 5'd0;
      end else if (bus.eret && old_exl) begin
        m_status[1] = 1'b0;
      end
      if (!take && bus.cp0_we && bus.cp0_addr == 5'd14) m_epc = bus.cp0_wdata;
      m_ip = bus.irq;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("trap", 32'(bus.trap), 32'(m_trap()));
      chk("trap_pc", bus.trap_pc, VECTOR);
      chk("eret_redirect", 32'(bus.eret_redirect), 32'(bus.eret && m_status[1]));
      chk("epc_out", bus.epc_out, m_epc);
      chk("double_fault", 32'(bus.double_fault), 32'(m_df));
      chk("cp0_rdata", bus.cp0_rdata, m_read());
      if (m_int_trap()) chk("irq_id", 32'(bus.irq_id), 32'(m_lowest()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string name, input logic [4:0] addr, input logic [31:0] exp);
    bus.cp0_addr = addr;
    #1;
    chk(name, bus.cp0_rdata, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.irq = '1; bus.exc_valid = 1'b0; bus.exc_code = 5'd0; bus.pc_in = 32'd0;
    bus.cp0_we = 1'b1; bus.cp0_addr = 5'd12; bus.cp0_wdata = 32'hFFFF_FFFF; bus.eret = 1'b0;
    step();
    bus.cp0_we = 1'b0;
    step();
    rd("rst_status", 5'd12, 32'd0);
    rd("rst_cause", 5'd13, 32'd0);
    rd("rst_epc", 5'd14, 32'd0);
    chk("rst_trap", 32'(bus.trap), 32'd0);

    rst_n = 1'b1; bus.irq = '0;
    step();

    // Interrupt entry with a second line rising in the trap cycle
    bus.cp0_we = 1'b1; bus.cp0_addr = 5'd12; bus.cp0_wdata = 32'h0000_0F01;
    step();
    bus.cp0_we = 1'b0; bus.irq = 6'b000100; bus.pc_in = 32'h0040_0010;
    step();
    bus.irq = 6'b000110; bus.pc_in = 32'h0040_0014;
    #1;
    chk("int_trap", 32'(bus.trap), 32'd1);
    chk("int_irq_id", 32'(bus.irq_id), 32'd2);
    step();
    rd("int_status", 5'd12, 32'h0000_0F03);
    rd("int_cause", 5'd13, 32'h0000_0600);
    chk("int_epc", bus.epc_out, 32'h0040_0014);
    chk("handler_no_trap", 32'(bus.trap), 32'd0);

    // eret from handler, then eret while running
    bus.irq = '0; bus.cp0_we = 1'b1; bus.cp0_addr = 5'd14; bus.cp0_wdata = 32'h0040_0020;
    step();
    bus.cp0_we = 1'b0; bus.eret = 1'b1;
    #1;
    chk("eret_redirect", 32'(bus.eret_redirect), 32'd1);
    chk("eret_target", bus.epc_out, 32'h0040_0020);
    step();
    bus.eret = 1'b0;
    rd("eret_status", 5'd12, 32'h0000_0F01);
    bus.eret = 1'b1;
    #1;
    chk("eret_in_run", 32'(bus.eret_redirect), 32'd0);
    step();
    bus.eret = 1'b0;

    // Masking: everything pending, nothing enabled, then unmask line 5
    bus.cp0_we = 1'b1; bus.cp0_addr = 5'd12; bus.cp0_wdata = 32'h0000_0001; bus.irq = 6'h3F;
    step();
    bus.cp0_we = 1'b0;
    step();
    chk("mask_no_trap", 32'(bus.trap), 32'd0);
    bus.cp0_we = 1'b1; bus.cp0_wdata = 32'h0000_2001;
    step();
    bus.cp0_we = 1'b0; bus.irq = '0; bus.pc_in = 32'h0040_0030;
    #1;
    chk("unmask_trap", 32'(bus.trap), 32'd1);
    chk("unmask_irq_id", 32'(bus.irq_id), 32'd5);
    step();
    chk("unmask_epc", bus.epc_out, 32'h0040_0030);
    bus.eret = 1'b1;
    step();
    bus.eret = 1'b0;

    // Exception beats a pending interrupt; second exception is a double fault
    bus.cp0_we = 1'b1; bus.cp0_addr = 5'd12; bus.cp0_wdata = 32'h0000_0101; bus.irq = 6'b000001;
    step();
    bus.cp0_we = 1'b0; bus.exc_valid = 1'b1; bus.exc_code = 5'd12; bus.pc_in = 32'h0040_0040;
    #1;
    chk("exc_trap", 32'(bus.trap), 32'd1);
    step();
    bus.exc_valid = 1'b0;
    rd("exc_cause", 5'd13, 32'h0000_0130);
    chk("exc_epc", bus.epc_out, 32'h0040_0040);
    bus.exc_valid = 1'b1; bus.exc_code = 5'd5; bus.pc_in = 32'h0040_0044;
    #1;
    chk("df_no_trap", 32'(bus.trap), 32'd0);
    step();
    bus.exc_valid = 1'b0;
    #1;
    chk("df_pulse", 32'(bus.double_fault), 32'd1);
    chk("df_epc", bus.epc_out, 32'h0040_0040);
    rd("df_cause", 5'd13, 32'h0000_0130);
    step();
    chk("df_clear", 32'(bus.double_fault), 32'd0);
    bus.irq = '0; bus.eret = 1'b1;
    step();
    bus.eret = 1'b0;

    // mtc0 Status collides with an exception take
    bus.exc_valid = 1'b1; bus.exc_code = 5'd4; bus.pc_in = 32'h0040_0050;
    bus.cp0_we = 1'b1; bus.cp0_addr = 5'd12; bus.cp0_wdata = 32'h0000_0000;
    step();
    bus.exc_valid = 1'b0; bus.cp0_we = 1'b0;
    rd("coll_status", 5'd12, 32'h0000_0002);
    chk("coll_epc", bus.epc_out, 32'h0040_0050);
    bus.cp0_we = 1'b1; bus.cp0_addr = 5'd13; bus.cp0_wdata = 32'hFFFF_FFFF;
    step();
    bus.cp0_we = 1'b0;
    rd("cause_ro", 5'd13, 32'h0000_0010);

    // Reset aborts the handler
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    rd("rst_handler_status", 5'd12, 32'd0);
    chk("rst_handler_epc", bus.epc_out, 32'd0);

    // mtc0 setting EXL forces the handler state
    bus.cp0_we = 1'b1; bus.cp0_addr = 5'd12; bus.cp0_wdata = 32'h0000_0002;
    step();
    bus.cp0_we = 1'b0; bus.exc_valid = 1'b1; bus.exc_code = 5'd10;
    #1;
    chk("forced_exl_no_trap", 32'(bus.trap), 32'd0);
    step();
    bus.exc_valid = 1'b0;
    rd("unmapped_read", 5'd3, 32'd0);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
